// File: rtl/sdio_pkg.sv
// sdio_pkg: state encodings, block limits and the block-size check
// shared by the SDIO data-path modules.
package sdio_pkg;
  localparam int SDIO_MAX_BLOCK = 512;
  localparam int SDIO_CNT_W     = 13;

  typedef enum logic [2:0] {
    IDLE,
    WR_RECV,
    WR_COMMIT,
    RD_FILL,
    RD_SEND,
    RD_WAIT,
    ERR
  } buf_state_t;

  function automatic logic size_bad(
    input logic [SDIO_CNT_W-1:0] cnt,
    input int                    depth_log2
  );
    return (cnt == '0) || (int'(cnt) > (1 << depth_log2));
  endfunction
endpackage

// File: rtl/sdio_buf_ram.sv
// sdio_buf_ram: simple dual-port byte RAM, one write port, one registered
// read port with write-through so a byte written this cycle reads back next.
module sdio_buf_ram #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [2**AW];
  logic [7:0] r_q;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else if (i_we && (i_waddr == i_raddr)) r_q <= i_wdata;
    else r_q <= r_mem[i_raddr];
  end

  assign o_rdata = r_q;
endmodule

// File: rtl/sdio_data_buffer.sv
// sdio_data_buffer: half-duplex block buffer between the SDIO PHY and the
// function layer. Define SDIO_BUF_CRC_GATE_EN to hide write bytes until CRC passes.
module sdio_data_buffer
  import sdio_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_activate,
  input  logic                  i_write_flag,
  input  logic [SDIO_CNT_W-1:0] i_data_count,
  input  logic                  i_phy_wr_stb,
  input  logic [7:0]            i_phy_wr_data,
  output logic                  o_phy_rd_stb,
  output logic [7:0]            o_phy_rd_data,
  input  logic                  i_phy_hst_rdy,
  output logic                  o_phy_com_rdy,
  input  logic                  i_phy_crc_good,
  output logic                  o_fn_wr_valid,
  output logic [7:0]            o_fn_wr_data,
  input  logic                  i_fn_wr_ready,
  input  logic                  i_fn_rd_valid,
  input  logic [7:0]            i_fn_rd_data,
  output logic                  o_fn_rd_ready,
  output logic                  o_done,
  output logic                  o_crc_err,
  output logic                  o_overflow,
  output logic                  o_size_err
);
  localparam int PW = DEPTH_LOG2 + 1;
`ifdef SDIO_BUF_CRC_GATE_EN
  localparam bit CRC_GATE = 1'b1;
`else
  localparam bit CRC_GATE = 1'b0;
`endif

  buf_state_t r_state, w_nstate;
  logic [PW-1:0] r_wr_ptr, r_rd_ptr, r_cmt_ptr;
  logic [PW-1:0] w_wr_ptr_nxt, w_rd_ptr_nxt, w_lim;
  logic [SDIO_CNT_W-1:0] r_count, r_rx_cnt, r_fill_cnt, r_sent, w_cnt;
  logic r_dir, r_act_d, r_pend, r_crc;
  logic r_com_rdy, r_done, r_crc_err, r_ovf, r_size_err;
  logic w_rise, w_fall, w_go, w_empty, w_full, w_bad, w_dir;
  logic w_fn_wr_xfer, w_fn_rd_xfer, w_phy_wr, w_ram_we;
  logic w_rd_mode, w_blk_ok, w_cancel;
  logic [7:0] w_ram_wdata, w_q;

  assign w_rise  = i_activate && !r_act_d;
  assign w_fall  = !i_activate && r_act_d;
  assign w_cnt   = w_rise ? i_data_count : r_count;
  assign w_dir   = w_rise ? i_write_flag : r_dir;
  assign w_bad   = size_bad(w_cnt, DEPTH_LOG2);
  assign w_empty = (r_rd_ptr == r_wr_ptr);
  assign w_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
  // A new transaction is held off until the previous write block drains.
  assign w_go     = i_activate && (w_rise || r_pend) && w_empty;
  assign w_blk_ok = r_crc && (r_rx_cnt == r_count);
  assign w_lim    = CRC_GATE ? r_cmt_ptr : r_wr_ptr;
  assign w_cancel = w_fall && ((r_state == RD_FILL) || (r_state == RD_SEND));

  assign o_fn_wr_valid = !w_rd_mode && (r_rd_ptr != w_lim);
  assign w_fn_wr_xfer  = o_fn_wr_valid && i_fn_wr_ready;
  assign w_fn_rd_xfer  = o_fn_rd_ready && i_fn_rd_valid;
  assign w_phy_wr      = (r_state == WR_RECV) && i_phy_wr_stb;
  assign w_ram_we      = (w_phy_wr && !w_full && (r_rx_cnt < r_count)) ||
                         w_fn_rd_xfer;
  assign w_ram_wdata   = (r_state == RD_FILL) ? i_fn_rd_data : i_phy_wr_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    unique case (r_state)
      IDLE:
        if (w_go) w_nstate = w_bad ? ERR : (w_dir ? WR_RECV : RD_FILL);
      WR_RECV:
        if (w_fall) w_nstate = WR_COMMIT;
      WR_COMMIT:
        w_nstate = IDLE;
      RD_FILL:
        if (w_fall) w_nstate = IDLE;
        else if (r_fill_cnt == r_count) w_nstate = RD_SEND;
      RD_SEND:
        if (w_fall) w_nstate = IDLE;
        else if (r_sent == r_count) w_nstate = RD_WAIT;
      RD_WAIT, ERR:
        if (w_fall) w_nstate = IDLE;
      default:
        w_nstate = IDLE;
    endcase
  end

  always_comb begin
    o_fn_rd_ready = 1'b0;
    o_phy_rd_stb  = 1'b0;
    w_rd_mode     = 1'b0;
    unique case (r_state)
      RD_FILL: begin
        w_rd_mode     = 1'b1;
        o_fn_rd_ready = !w_full && (r_fill_cnt < r_count);
      end
      RD_SEND: begin
        w_rd_mode    = 1'b1;
        o_phy_rd_stb = i_phy_hst_rdy && (r_sent < r_count);
      end
      RD_WAIT, ERR:
        w_rd_mode = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    if (w_ram_we) w_wr_ptr_nxt = r_wr_ptr + PW'(1);
    if ((r_state == WR_COMMIT) && CRC_GATE && !w_blk_ok)
      w_wr_ptr_nxt = r_cmt_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_fn_wr_xfer || o_phy_rd_stb) w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    if (w_cancel) w_rd_ptr_nxt = w_wr_ptr_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cmt_ptr  <= '0;
      r_count    <= '0;
      r_rx_cnt   <= '0;
      r_fill_cnt <= '0;
      r_sent     <= '0;
      r_dir      <= 1'b0;
      r_act_d    <= 1'b0;
      r_pend     <= 1'b0;
      r_crc      <= 1'b0;
      r_com_rdy  <= 1'b0;
      r_done     <= 1'b0;
      r_crc_err  <= 1'b0;
      r_ovf      <= 1'b0;
      r_size_err <= 1'b0;
    end else begin
      r_act_d    <= i_activate;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_com_rdy  <= (w_nstate == RD_SEND);
      r_done     <= 1'b0;
      r_crc_err  <= 1'b0;
      r_size_err <= 1'b0;
      r_pend     <= i_activate && (w_rise || r_pend) &&
                    !((r_state == IDLE) && w_go);
      if (w_rise) begin
        r_count <= i_data_count;
        r_dir   <= i_write_flag;
        r_ovf   <= 1'b0;
      end
      if ((r_state == IDLE) && w_go) begin
        r_rx_cnt   <= '0;
        r_fill_cnt <= '0;
        r_sent     <= '0;
        r_size_err <= w_bad;
      end
      if (w_phy_wr && w_ram_we) r_rx_cnt <= r_rx_cnt + 1'b1;
      if (w_phy_wr && w_full) r_ovf <= 1'b1;
      if ((r_state == WR_RECV) && w_fall) r_crc <= i_phy_crc_good;
      if (r_state == WR_COMMIT) begin
        r_done    <= w_blk_ok;
        r_crc_err <= !w_blk_ok;
        r_cmt_ptr <= w_wr_ptr_nxt;
      end
      if (w_rd_mode) r_cmt_ptr <= w_wr_ptr_nxt;
      if (w_fn_rd_xfer) r_fill_cnt <= r_fill_cnt + 1'b1;
      if (o_phy_rd_stb) r_sent <= r_sent + 1'b1;
      if ((r_state == RD_WAIT) && w_fall) r_done <= 1'b1;
    end
  end

  sdio_buf_ram #(.AW(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr[PW-2:0]),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_rd_ptr_nxt[PW-2:0]),
    .o_rdata (w_q)
  );

  assign o_fn_wr_data  = w_q;
  assign o_phy_rd_data = w_q;
  assign o_phy_com_rdy = r_com_rdy;
  assign o_done        = r_done;
  assign o_crc_err     = r_crc_err;
  assign o_overflow    = r_ovf;
  assign o_size_err    = r_size_err;
endmodule
